// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, key codes and winner codes for the pong score keeper
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [7:0] KEY_START   = 8'd103;
    localparam logic [7:0] KEY_RESTART = 8'd98;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/serve_timer.sv
// rtl/serve_timer.sv - frame-tick countdown that fires done on the tick reaching zero
module serve_timer #(
    parameter int unsigned FRAMES = 60
) (
    input  logic i_CLK,
    input  logic i_RST_N,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_done
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = 8'd0;
        end else if (i_load) begin
            cnt_d = 8'(FRAMES);
        end else if (i_tick && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A fresh load or clear in the same cycle overrides a pending expiry.
    assign o_done = i_tick && (cnt_q == 8'd1) && !i_load && !i_clear;

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - pong game flow: scores, serve delay, win detection and key control
module score_keeper
    import pong_pkg::*;
#(
    parameter logic [7:0]  START        = KEY_START,
    parameter logic [7:0]  RESTART      = KEY_RESTART,
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic [7:0] i_key_byte,
    input  logic       i_frame_tick,
    input  logic       i_p1_scored,
    input  logic       i_p2_scored,
    output logic [3:0] o_p1_score,
    output logic [3:0] o_p2_score,
    output logic [1:0] o_state,
    output logic       o_ball_enable,
    output logic [1:0] o_winner,
    output logic       o_serve_dir
);

    localparam logic [3:0] WIN4 = 4'(WIN_SCORE);

    state_e     state_q, state_d;
    logic [3:0] p1_q, p1_d, p2_q, p2_d;
    logic [1:0] win_q, win_d;
    logic       dir_q, dir_d;
    logic       ben_q, ben_d;
    logic       p1_prev_q, p2_prev_q;
    logic       p1_edge, p2_edge;
    logic [3:0] p1_next, p2_next;
    logic       timer_load, timer_clear, timer_done;

    assign p1_edge = i_p1_scored && !p1_prev_q;
    assign p2_edge = i_p2_scored && !p2_prev_q;
    assign p1_next = p1_q + 4'd1;
    assign p2_next = p2_q + 4'd1;

    serve_timer #(
        .FRAMES (SERVE_FRAMES)
    ) u_serve_timer (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_load  (timer_load),
        .i_clear (timer_clear),
        .i_tick  (i_frame_tick),
        .o_done  (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        win_d       = win_q;
        dir_d       = dir_q;
        timer_load  = 1'b0;
        timer_clear = 1'b0;

        if (i_key_byte == RESTART) begin
            state_d     = ST_IDLE;
            p1_d        = 4'd0;
            p2_d        = 4'd0;
            win_d       = WIN_NONE;
            dir_d       = DIR_RIGHT;
            timer_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_key_byte == START) begin
                        state_d    = ST_SERVE;
                        timer_load = 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (timer_done) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // A tie-edge is a void rally: re-serve in the same direction.
                    if (p1_edge && p2_edge) begin
                        state_d    = ST_SERVE;
                        timer_load = 1'b1;
                    end else if (p1_edge) begin
                        p1_d = p1_next;
                        if (p1_next == WIN4) begin
                            state_d = ST_OVER;
                            win_d   = WIN_P1;
                        end else begin
                            state_d    = ST_SERVE;
                            dir_d      = DIR_RIGHT;
                            timer_load = 1'b1;
                        end
                    end else if (p2_edge) begin
                        p2_d = p2_next;
                        if (p2_next == WIN4) begin
                            state_d = ST_OVER;
                            win_d   = WIN_P2;
                        end else begin
                            state_d    = ST_SERVE;
                            dir_d      = DIR_LEFT;
                            timer_load = 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (i_key_byte == START) begin
                        state_d    = ST_SERVE;
                        p1_d       = 4'd0;
                        p2_d       = 4'd0;
                        win_d      = WIN_NONE;
                        dir_d      = DIR_RIGHT;
                        timer_load = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        ben_d = (state_d == ST_PLAY);
    end

    // Edge history resets high so a flag already asserted at release never scores.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q   <= ST_IDLE;
            p1_q      <= 4'd0;
            p2_q      <= 4'd0;
            win_q     <= WIN_NONE;
            dir_q     <= DIR_RIGHT;
            ben_q     <= 1'b0;
            p1_prev_q <= 1'b1;
            p2_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            win_q     <= win_d;
            dir_q     <= dir_d;
            ben_q     <= ben_d;
            p1_prev_q <= i_p1_scored;
            p2_prev_q <= i_p2_scored;
        end
    end

    assign o_p1_score    = p1_q;
    assign o_p2_score    = p2_q;
    assign o_state       = state_q;
    assign o_ball_enable = ben_q;
    assign o_winner      = win_q;
    assign o_serve_dir   = dir_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - table-driven and directed checks for score_keeper
module tb_score_keeper;

    localparam logic [7:0] K_START   = 8'd103;
    localparam logic [7:0] K_RESTART = 8'd98;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key = 8'd0;
    logic       tick = 1'b0;
    logic       p1 = 1'b0;
    logic       p2 = 1'b0;
    logic [3:0] p1_score, p2_score;
    logic [1:0] state, winner;
    logic       ball_en, serve_dir;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    score_keeper dut (
        .i_CLK         (clk),
        .i_RST_N       (rst_n),
        .i_key_byte    (key),
        .i_frame_tick  (tick),
        .i_p1_scored   (p1),
        .i_p2_scored   (p2),
        .o_p1_score    (p1_score),
        .o_p2_score    (p2_score),
        .o_state       (state),
        .o_ball_enable (ball_en),
        .o_winner      (winner),
        .o_serve_dir   (serve_dir)
    );

    typedef struct {
        int         reps;
        logic [7:0] key;
        logic       tick;
        logic       p1;
        logic       p2;
        logic [1:0] st;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] win;
        logic       dir;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int reps, logic [7:0] k, logic t, logic a, logic b,
                                logic [1:0] st, logic [3:0] s1, logic [3:0] s2,
                                logic [1:0] w, logic d);
        vec_t v;
        v.reps = reps; v.key = k; v.tick = t; v.p1 = a; v.p2 = b;
        v.st = st; v.s1 = s1; v.s2 = s2; v.win = w; v.dir = d;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [3:0] s1,
                             input logic [3:0] s2, input logic [1:0] w, input logic d);
        check({tag, " state"}, state, st);
        check({tag, " p1"}, p1_score, s1);
        check({tag, " p2"}, p2_score, s2);
        check({tag, " winner"}, winner, w);
        check({tag, " dir"}, serve_dir, d);
        check({tag, " ball_en"}, ball_en, (st == 2'd2));
    endtask

    // Drive at the falling edge, let one rising edge pass, end on the next falling edge.
    task automatic run(input int reps, input logic [7:0] k, input logic t,
                       input logic a, input logic b);
        for (int r = 0; r < reps; r++) begin
            key = k; tick = t; p1 = a; p2 = b;
            @(negedge clk);
        end
    endtask

    initial begin
        add(1, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, K_START, 0, 0, 0, 1, 0, 0, 0, 0);
        add(59, K_START, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 8'd0, 1, 0, 0, 2, 0, 0, 0, 0);
        add(5, 8'd0, 0, 1, 0, 1, 1, 0, 0, 0);
        add(60, 8'd0, 1, 0, 0, 2, 1, 0, 0, 0);
        add(1, 8'd0, 0, 0, 1, 1, 1, 1, 0, 1);
        add(60, 8'd0, 1, 0, 0, 2, 1, 1, 0, 1);
        add(1, 8'd0, 0, 1, 1, 1, 1, 1, 0, 1);
        add(60, 8'd0, 1, 1, 1, 2, 1, 1, 0, 1);
        add(2, 8'd0, 0, 0, 0, 2, 1, 1, 0, 1);
        for (int k = 2; k <= 6; k++) begin
            add(1, 8'd0, 0, 0, 1, 1, 1, 4'(k), 0, 1);
            add(60, 8'd0, 1, 0, 0, 2, 1, 4'(k), 0, 1);
        end
        add(1, 8'd0, 0, 0, 1, 3, 1, 7, 2, 1);
        add(1, 8'd0, 0, 0, 0, 3, 1, 7, 2, 1);
        add(1, 8'd0, 0, 0, 1, 3, 1, 7, 2, 1);
        add(1, 8'd0, 1, 1, 0, 3, 1, 7, 2, 1);
        add(1, 8'd0, 0, 0, 0, 3, 1, 7, 2, 1);
        add(1, K_START, 0, 0, 0, 1, 0, 0, 0, 0);
        add(30, 8'd0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, K_RESTART, 0, 0, 0, 0, 0, 0, 0, 0);
        add(5, 8'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, K_START, 0, 0, 0, 1, 0, 0, 0, 0);
        add(60, 8'd0, 1, 0, 0, 2, 0, 0, 0, 0);
        add(1, 8'd0, 0, 1, 0, 1, 1, 0, 0, 0);
        add(60, 8'd0, 1, 0, 0, 2, 1, 0, 0, 0);
        add(1, 8'd0, 0, 0, 1, 1, 1, 1, 0, 1);
        add(60, 8'd0, 1, 0, 0, 2, 1, 1, 0, 1);
        add(1, 8'd0, 0, 1, 0, 1, 2, 1, 0, 0);
        add(60, 8'd0, 1, 0, 0, 2, 2, 1, 0, 0);
        add(1, 8'd0, 0, 0, 1, 1, 2, 2, 0, 1);
        add(60, 8'd0, 1, 0, 0, 2, 2, 2, 0, 1);
        add(1, 8'd0, 0, 1, 0, 1, 3, 2, 0, 0);
        add(60, 8'd0, 1, 0, 0, 2, 3, 2, 0, 0);
        add(1, K_START, 0, 0, 0, 2, 3, 2, 0, 0);
        add(1, K_RESTART, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, K_START, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, K_RESTART, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Outputs while reset is held.
        #1;
        check_all("reset", 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run(tbl[i].reps, tbl[i].key, tbl[i].tick, tbl[i].p1, tbl[i].p2);
            check_all($sformatf("v%0d", i), tbl[i].st, tbl[i].s1, tbl[i].s2,
                      tbl[i].win, tbl[i].dir);
        end

        // Reset mid-serve with a point on the board and p1 flag held through release.
        run(1, K_START, 0, 0, 0);
        run(60, 8'd0, 1, 0, 0);
        run(1, 8'd0, 0, 1, 0);
        run(10, 8'd0, 1, 0, 0);
        check_all("pre_rst", 1, 1, 0, 0, 0);
        p1 = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(3, 8'd0, 0, 1, 0);
        check_all("post_rst", 0, 0, 0, 0, 0);
        run(1, K_START, 0, 1, 0);
        run(60, 8'd0, 1, 1, 0);
        check_all("held_play", 2, 0, 0, 0, 0);
        run(2, 8'd0, 0, 1, 0);
        check_all("held_more", 2, 0, 0, 0, 0);
        run(1, 8'd0, 0, 0, 0);
        run(1, 8'd0, 0, 1, 0);
        check_all("fresh_edge", 1, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter START, default 103, key byte that starts a game or serve.
REQ-002 SHALL have parameter RESTART, default 98, key byte that aborts to idle and clears scores.
REQ-003 SHALL have parameter WIN_SCORE, default 7, points needed to win (1..15).
REQ-004 SHALL have parameter SERVE_FRAMES, default 60, frame ticks of serve delay (1..255).
REQ-005 SHALL have port i_CLK  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_RST_N  input  1  asynchronous active-low reset.
REQ-007 SHALL have port i_key_byte  input  8  latest keyboard byte, level.
REQ-008 SHALL have port i_frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 SHALL have port i_p1_scored  input  1  player-1 point flag from ball logic, may stay high several cycles.
REQ-010 SHALL have port i_p2_scored  input  1  player-2 point flag, same behaviour.
REQ-011 SHALL have port o_p1_score  output  4  player-1 score.
REQ-012 SHALL have port o_p2_score  output  4  player-2 score.
REQ-013 SHALL have port o_state  output  2  IDLE=0, SERVE=1, PLAY=2, OVER=3.
REQ-014 SHALL have port o_ball_enable  output  1  high only in PLAY; ball logic holds ball at centre when low.
REQ-015 SHALL have port o_winner  output  2  0 none, 1 player 1, 2 player 2.
REQ-016 SHALL have port o_serve_dir  output  1  0 = serve right, 1 = serve left.

Function
REQ-017 SHALL count a point only on a rising edge of i_pX_scored (current high, previous-cycle registered value low); a held flag counts once.
REQ-018 SHALL update the score register on the same clock edge that first samples the flag high; visible the following cycle.
REQ-019 SHALL ignore score edges in IDLE, SERVE and OVER.
REQ-020 SHALL, on simultaneous p1 and p2 edges in PLAY, count neither point and go to SERVE with o_serve_dir unchanged.
REQ-021 SHALL transition IDLE->SERVE when i_key_byte==START; scores already zero.
REQ-022 SHALL, on SERVE entry, load a countdown with SERVE_FRAMES; decrement on each i_frame_tick; go to PLAY on the tick that reaches zero.
REQ-023 SHALL transition PLAY->SERVE on a single-player edge when the new score < WIN_SCORE; o_serve_dir set toward the scorer's opponent (p1 point -> 0, p2 point -> 1).
REQ-024 SHALL transition PLAY->OVER when the new score == WIN_SCORE; o_winner set the same edge.
REQ-025 SHALL transition OVER->SERVE on START, clearing both scores and o_winner, o_serve_dir to 0.
REQ-026 SHALL transition any state->IDLE on RESTART, clearing scores, o_winner, o_serve_dir and countdown; RESTART takes priority over all other events in the same cycle.
REQ-027 SHALL never exceed WIN_SCORE in a score; no wrap-around possible.
REQ-028 SHALL treat START in SERVE or PLAY as no effect.
REQ-029 SHALL drive all outputs directly from registers (no combinational input-to-output path).

Reset
REQ-030 SHALL, while i_RST_N low, force state IDLE, scores 0, o_winner 0, o_serve_dir 0, o_ball_enable 0, countdown 0, edge-detect history 1 (so a flag high at reset release is not counted).
REQ-031 SHALL resume normal operation on the first i_CLK edge after i_RST_N deasserts; reset mid-serve or mid-play discards all progress.

Structure
REQ-032 SHALL take state encoding, START/RESTART key codes and winner codes from shared package pong_pkg.
REQ-033 SHALL instantiate one sub-module serve_timer (load, tick, done) for the frame countdown.

Verification
REQ-034 Reset, START, 60 frame ticks -> o_state 1 then 2 on 60th tick, o_ball_enable 1.
REQ-035 In PLAY, i_p1_scored high 5 cycles -> o_p1_score 1 (not 5), o_state SERVE, o_serve_dir 0.
REQ-036 p2 scores 7 single pulses with serves between -> o_p2_score 7, o_state 3, o_winner 2; further pulses ignored.
REQ-037 p1 and p2 flags rise same cycle in PLAY -> scores unchanged, o_state SERVE.
REQ-038 START and RESTART alternating while in PLAY with score 3-2 -> RESTART yields IDLE, scores 0-0.
REQ-039 i_RST_N low mid-SERVE with i_p1_scored held high through release -> IDLE, scores 0, no point counted.
